// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between operand fetch, the ALU execute unit and writeback.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never depends on ready.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       Control;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             Illegal;

  modport slave (
    input  InValid, Control, OpA, OpB, OutReady,
    output InReady, OutValid, Result, Zero, Overflow, Illegal
  );

  modport master (
    output InValid, Control, OpA, OpB, OutReady,
    input  InReady, OutValid, Result, Zero, Overflow, Illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: computes the op at push time and queues result/flags in a 2-entry FIFO.
// Upstream only stalls when both entries are held by downstream backpressure.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_unit_if.slave   bus,
  output logic             ErrSticky,
  output logic [CNT_W-1:0] OpCount
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] res_q [2];
  logic             ovf_q [2];
  logic             ill_q [2];
  logic             err_q;
  logic [CNT_W-1:0] ops_q;

  logic             push, pop;
  logic [WIDTH-1:0] sum, diff, alu_res, head_res;
  logic             alu_ovf, alu_ill;

  assign bus.InReady  = (count_q != 2'd2);
  assign bus.OutValid = (count_q != 2'd0);
  assign push         = bus.InValid & bus.InReady;
  assign pop          = bus.OutValid & bus.OutReady;

  always_comb begin
    sum     = bus.OpA + bus.OpB;
    diff    = bus.OpA - bus.OpB;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.Control)
      OP_AND: alu_res = bus.OpA & bus.OpB;
      OP_OR:  alu_res = bus.OpA | bus.OpB;
      OP_NOR: alu_res = ~(bus.OpA | bus.OpB);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.OpA[WIDTH-1] == bus.OpB[WIDTH-1]) && (sum[WIDTH-1] != bus.OpA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.OpA[WIDTH-1] != bus.OpB[WIDTH-1]) && (diff[WIDTH-1] != bus.OpA[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.OpA) < $signed(bus.OpB))};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      err_q    <= 1'b0;
      ops_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
        ill_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        res_q[wr_ptr_q] <= alu_res;
        ovf_q[wr_ptr_q] <= alu_ovf;
        ill_q[wr_ptr_q] <= alu_ill;
        wr_ptr_q        <= ~wr_ptr_q;
        if (alu_ill) err_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        ops_q    <= ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Head fields are forced to zero while empty so stale entries never leak out.
  assign head_res     = bus.OutValid ? res_q[rd_ptr_q] : '0;
  assign bus.Result   = head_res;
  assign bus.Zero     = bus.OutValid && (head_res == '0);
  assign bus.Overflow = bus.OutValid && ovf_q[rd_ptr_q];
  assign bus.Illegal  = bus.OutValid && ill_q[rd_ptr_q];
  assign ErrSticky    = err_q;
  assign OpCount      = ops_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, backpressure ordering, async reset flush.
module tb_alu_exec_unit;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic             clk;
  logic             rst_n;
  logic             ErrSticky;
  logic [CNT_W-1:0] OpCount;
  logic [CNT_W-1:0] exp_cnt;
  int               total;
  int               bad;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ErrSticky (ErrSticky),
    .OpCount   (OpCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    while (!bus.InReady && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.InReady) check("push_ready_timeout", 32'd0, 32'd1);
    bus.Control = ctrl;
    bus.OpA     = a;
    bus.OpB     = b;
    bus.InValid = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_res, input logic e_z,
                        input logic e_ov, input logic e_ill);
    push_op(ctrl, a, b);
    check({tag, "_valid"}, {31'd0, bus.OutValid}, 32'd1);
    check({tag, "_result"}, bus.Result, e_res);
    check({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, e_z});
    check({tag, "_ovf"}, {31'd0, bus.Overflow}, {31'd0, e_ov});
    check({tag, "_illegal"}, {31'd0, bus.Illegal}, {31'd0, e_ill});
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    bus.OutReady = 1'b0;
    exp_cnt++;
    check({tag, "_opcount"}, {28'd0, OpCount}, {28'd0, exp_cnt});
    check({tag, "_empty"}, {31'd0, bus.OutValid}, 32'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    exp_cnt      = '0;
    rst_n        = 1'b0;
    bus.InValid  = 1'b0;
    bus.Control  = 4'b0000;
    bus.OpA      = '0;
    bus.OpB      = '0;
    bus.OutReady = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outvalid", {31'd0, bus.OutValid}, 32'd0);
    check("rst_inready", {31'd0, bus.InReady}, 32'd1);
    check("rst_result", bus.Result, 32'd0);
    check("rst_opcount", {28'd0, OpCount}, 32'd0);
    check("rst_err", {31'd0, ErrSticky}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First op with downstream always ready: visible one cycle after accept, popped the next.
    bus.OutReady = 1'b1;
    push_op(C_ADD, 32'd5, 32'd7);
    check("add1_valid", {31'd0, bus.OutValid}, 32'd1);
    check("add1_result", bus.Result, 32'd12);
    check("add1_zero", {31'd0, bus.Zero}, 32'd0);
    check("add1_ovf", {31'd0, bus.Overflow}, 32'd0);
    check("add1_illegal", {31'd0, bus.Illegal}, 32'd0);
    @(posedge clk); #1;
    bus.OutReady = 1'b0;
    exp_cnt++;
    check("add1_opcount", {28'd0, OpCount}, 32'd1);
    check("add1_empty", {31'd0, bus.OutValid}, 32'd0);

    run_op("sub_zero", C_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", C_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    run_op("slt_pos", C_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("nor", C_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("and", C_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    run_op("or", C_OR, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    check("err_before_illegal", {31'd0, ErrSticky}, 32'd0);

    run_op("illegal", 4'b1111, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b1);
    check("err_after_illegal", {31'd0, ErrSticky}, 32'd1);
    run_op("legal_after", C_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    check("err_kept", {31'd0, ErrSticky}, 32'd1);

    // Backpressure: two accepts fill the buffer, third op is held until a slot frees.
    bus.Control = C_ADD; bus.OpA = 32'd10; bus.OpB = 32'd20; bus.InValid = 1'b1;
    @(posedge clk); #1;
    check("bp_ready1", {31'd0, bus.InReady}, 32'd1);
    bus.Control = C_SUB; bus.OpA = 32'd100; bus.OpB = 32'd1;
    @(posedge clk); #1;
    check("bp_full", {31'd0, bus.InReady}, 32'd0);
    check("bp_head1", bus.Result, 32'd30);
    bus.Control = C_OR; bus.OpA = 32'd1; bus.OpB = 32'd2;
    @(posedge clk); #1;
    check("bp_still_full", {31'd0, bus.InReady}, 32'd0);
    check("bp_head_stable", bus.Result, 32'd30);
    check("bp_valid_stable", {31'd0, bus.OutValid}, 32'd1);
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    check("bp_order2", bus.Result, 32'd99);
    check("bp_ready_again", {31'd0, bus.InReady}, 32'd1);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    exp_cnt++;
    check("bp_order3", bus.Result, 32'd3);
    check("bp_valid3", {31'd0, bus.OutValid}, 32'd1);
    @(posedge clk); #1;
    bus.OutReady = 1'b0;
    exp_cnt++;
    check("bp_drained", {31'd0, bus.OutValid}, 32'd0);
    check("bp_opcount", {28'd0, OpCount}, {28'd0, exp_cnt});

    // Enough further pops to carry the narrow counter through its wrap.
    for (int i = 0; i < 4; i++) begin
      run_op("wrap_add", C_ADD, i, i, 2 * i, (i == 0), 1'b0, 1'b0);
    end
    check("opcount_wrapped", {28'd0, OpCount}, 32'd2);

    // Asynchronous reset mid-cycle with the buffer full.
    push_op(C_ADD, 32'd1, 32'd2);
    push_op(C_ADD, 32'd3, 32'd4);
    check("pre_rst_full", {31'd0, bus.InReady}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("arst_outvalid", {31'd0, bus.OutValid}, 32'd0);
    check("arst_inready", {31'd0, bus.InReady}, 32'd1);
    check("arst_opcount", {28'd0, OpCount}, 32'd0);
    check("arst_err", {31'd0, ErrSticky}, 32'd0);
    check("arst_result", bus.Result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", C_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
